// File: rtl/demux_4b_1to2_buf_pkg.sv
// Shared constants and types for the buffered 1-to-2 demux and its FIFOs.
// SEL_PORT* use the same encoding as the 2-to-1 select mux (0 = x side, 1 = y side).
package demux_4b_1to2_buf_pkg;

  localparam int DMX_WIDTH         = 4;
  localparam int DMX_DEPTH_DEFAULT = 2;

  localparam logic SEL_PORT0 = 1'b0;
  localparam logic SEL_PORT1 = 1'b1;

  typedef enum logic {
    FIFO_EMPTY    = 1'b0,
    FIFO_NONEMPTY = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/demux_4b_1to2_buf_fifo.sv
// Non-fall-through synchronous FIFO: a push is visible at rdata one cycle later.
// Pushes while full and pops while empty are ignored; full and empty derive from a level counter.
module sync_fifo_nb
  import demux_4b_1to2_buf_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int DEPTH = DMX_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  fifo_state_e      state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (state_q == FIFO_EMPTY);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign level   = level_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    state_d = state_q;

    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Full is not a state: only the empty/non-empty boundary changes state.
    case (state_q)
      FIFO_EMPTY: begin
        if (do_push && !do_pop) state_d = FIFO_NONEMPTY;
      end
      FIFO_NONEMPTY: begin
        if (do_pop && !do_push && level_q == LVL_W'(1)) state_d = FIFO_EMPTY;
      end
      default: state_d = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FIFO_EMPTY;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/demux_4b_1to2_buf.sv
// Buffered 1-to-2 demux: steers each accepted word by in_sel into one of two FIFOs.
// in_ready reflects only the selected FIFO's full flag, so one stalled port never blocks the other.
module demux_4b_1to2_buf
  import demux_4b_1to2_buf_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int DEPTH = DMX_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out0_data,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [$clog2(DEPTH):0] out0_level,
  output logic [WIDTH-1:0]       out1_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [$clog2(DEPTH):0] out1_level
);

  logic push0, push1;
  logic pop0, pop1;
  logic empty0, empty1;
  logic full0, full1;
  logic accept;

  assign in_ready = (in_sel == SEL_PORT1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (in_sel == SEL_PORT0);
  assign push1    = accept && (in_sel == SEL_PORT1);

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  sync_fifo_nb #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .wdata (in_data),
    .rdata (out0_data),
    .empty (empty0),
    .full  (full0),
    .level (out0_level)
  );

  sync_fifo_nb #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .wdata (in_data),
    .rdata (out1_data),
    .empty (empty1),
    .full  (full1),
    .level (out1_level)
  );

endmodule

// File: doc/demux_4b_1to2_buf.md
# demux_4b_1to2_buf

Buffered 4-bit 1-to-2 demultiplexer: the distributing counterpart of the 4-bit 2-to-1 select mux in the processor datapath. It accepts one 4-bit word per cycle on a valid/ready input stream and steers it, by a per-word select bit, into one of two per-destination FIFOs. Each destination drains independently through its own valid/ready port. It sits between a single producer, such as an ALU result or fetch nibble, and two consumer paths, such as write-back and forwarding.

## Interface
- WIDTH, 4, data width; the block is verified at 4 only.
- DEPTH, 2, entries per destination FIFO; power of two, at least 2.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_data  in  WIDTH  word to route
- in_sel  in  1  destination: 0 selects port 0, 1 selects port 1 (same encoding as the 2-to-1 mux select: 0 = x side, 1 = y side)
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept the word for the currently selected destination
- out0_data / out1_data  out  WIDTH  head word of each FIFO
- out0_valid / out1_valid  out  1  FIFO non-empty
- out0_ready / out1_ready  in  1  consumer takes the head word
- out0_level / out1_level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Accept: a transfer occurs when in_valid and in_ready are both high at a clk edge. The word is written to the tail of FIFO[in_sel].
- in_ready is !full(FIFO[in_sel]) and is combinational on in_sel.
  - in_ready is independent of in_valid and of either out*_ready.
  - Backpressure on one destination never blocks words routed to the other.
- Pop: when outN_valid and outN_ready are both high at a clk edge, the head of FIFO N is removed.
  - outN_ready while outN_valid is low has no effect.
- outN_data equals the storage entry at the read pointer. Its value is don't-care when outN_valid is low, except after reset, when it is 0.
- Full FIFO with a simultaneous pop and an incoming word for it: in_ready stays low that cycle, so no push happens and only the pop completes. In the following cycle in_ready is high.
- Empty FIFO: no pop is possible, and a push makes outN_valid high on the next cycle. There is no fall-through.
- Pushing to FIFO 0 while popping FIFO 1 (or the reverse) in the same cycle: both complete.
- Push and pop on the same non-full, non-empty FIFO in the same cycle: level is unchanged and order is preserved.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Level is tracked in a separate counter of width $clog2(DEPTH)+1. Full means level == DEPTH; empty means level == 0.
- Each FIFO has exactly two states:
  - EMPTY goes to NONEMPTY on push without pop.
  - NONEMPTY goes to EMPTY when a pop takes level from 1 to 0.
  - full is a flag derived from level, not a separate state.
- Words are never dropped or duplicated. Per-destination order equals input order.

## Timing
- Reset values: in_ready = 1, outN_valid = 0, outN_level = 0, outN_data = 0, all pointers 0, storage cleared.
- Reset asserted mid-operation discards all buffered words at that edge. Any handshake sampled in the same cycle as reset is ignored.
- Latency from accept to visible at the output: 1 cycle if the target FIFO was empty, otherwise behind the queued words.
- Throughput: 1 word per cycle in, and 1 word per cycle per output, sustained.
- Levels update at the edge following the handshake.
- Single clock domain with no multicycle paths. The only combinational path from input to output is in_sel to in_ready.

## Structure
- The shared package holds:
  - DMX_WIDTH = 4.
  - DMX_DEPTH_DEFAULT = 2.
  - The select encoding constants SEL_PORT0 = 1'b0 and SEL_PORT1 = 1'b1, shared with the 2-to-1 mux users.
- Sub-module sync_fifo_nb (parameters WIDTH, DEPTH; ports push, pop, wdata, rdata, empty, full, level) is instantiated twice.
- The top level contains only steering logic: push decode from in_sel and in_ready, ready mux, and pop wiring.

## Test plan
- Reset then idle: after reset is held 2 cycles, in_ready = 1, both valids 0, both levels 0, both data 0.
- Steering: send 4'hA with sel=0 and 4'h5 with sel=1, outputs held not-ready. Required: out0_data = A, out1_data = 5, both levels 1, both valids high one cycle after each accept.
- Full/backpressure, DEPTH=2: push 4'h1 then 4'h2 to port 0 with out0_ready = 0, then present 4'h3 with sel=0. Required: in_ready = 0 and level stays 2. Switching in_sel to 1 raises in_ready in the same cycle, and 4'h3 lands in port 1.
- Full with simultaneous pop: port 0 full with {1, 2}; in one cycle assert out0_ready and present 4'h3 with sel=0. Required: 1 pops, 3 is not accepted that cycle, and 3 is accepted the next cycle. Port 0 then yields 2 then 3.
- Wrap-around and streaming: 16 words 0..F alternating sel, both readys high. Required: each port receives its 8 words in order, no gaps after the first output cycle, levels never exceed 1.
- Reset mid-stream: port 0 holds 2 words and port 1 holds 1; assert reset together with in_valid and out0_ready. Required: on the next cycle everything is at reset values, no pop and no push took effect, and later traffic starts from empty.
